kronos_imem_wb: RTL and testbench

- Instruction-memory bridge directly upstream of the instruction-fetch stage.
- Converts the fetch stage's always-requesting address/ack interface to a Wishbone classic read-only master, which allows wait-state memories and bus fabrics.
- Provides one-block lookahead (a new address is accepted in the same cycle a response is returned), redirect handling when the fetch address changes mid-transaction, and a bus timeout that returns a fault response.

---
 rtl/kronos_imem_wb.sv | 110 +++++++++++
 tb/tb_kronos_imem_wb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_imem_wb.sv
// kronos_imem_wb: fetch address/ack port to Wishbone classic read master.
// Single outstanding access with lookahead, redirect drop and bus timeout.
module kronos_imem_wb #(
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] FAULT_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t        r_state;
  logic [29:0]   r_adr;
  logic          r_cyc;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_data;
  logic [CW-1:0] r_cnt;

  logic w_match;
  logic w_tout;
  logic w_done;
  logic w_fault;
  logic w_unused;

  // Byte offset never reaches the bus or the redirect compare
  assign w_unused = ^instr_addr[1:0];

  assign w_match = instr_req && (instr_addr[31:2] == r_adr);
  assign w_tout  = (TIMEOUT != 0) && (r_cnt == TMAX);
  assign w_done  = wb_err_i || wb_ack_i || w_tout;
  assign w_fault = wb_err_i || !wb_ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_cyc   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        IDLE, RESP: begin
          if (instr_req) begin
            r_adr   <= instr_addr[31:2];
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
            r_state <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_cyc <= 1'b0;
            // A stale response is dropped; IDLE re-latches next cycle
            if (w_match) begin
              r_ack   <= 1'b1;
              r_err   <= w_fault;
              r_data  <= w_fault ? FAULT_INSTR : wb_dat_i;
              r_state <= RESP;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cyc   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign wb_adr_o   = {r_adr, 2'b00};
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_cyc;
  assign wb_we_o    = 1'b0;
  assign wb_sel_o   = 4'hF;
  assign instr_ack  = r_ack;
  assign instr_err  = r_err;
  assign instr_data = r_data;

endmodule

// File: tb/tb_kronos_imem_wb.sv
// tb_kronos_imem_wb: directed fetch scenarios against a cycle model of the
// bridge, plus a TIMEOUT=0 instance that must wait forever on a silent bus.
module tb_kronos_imem_wb;

  localparam int T1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = 32'h0;

  logic [31:0] d_data, adr, wb_dat;
  logic        d_ack, d_err, cyc, stb, we;
  logic [3:0]  sel;
  logic        wb_ack, wb_err;

  logic [31:0] d2_data, adr2;
  logic        d2_ack, d2_err, cyc2, stb2, we2;
  logic [3:0]  sel2;

  int total = 0;
  int bad = 0;

  // slave: 0 normal, 1 error, 2 ack+err, 3 silent
  int   s_mode = 0;
  int   s_wait = 0;
  int   s_cnt = 0;
  logic f_ack = 1'b0;
  logic f_err = 1'b0;
  logic s_hit;

  kronos_imem_wb #(.TIMEOUT(T1)) dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_req(instr_req),
    .instr_data(d_data), .instr_ack(d_ack), .instr_err(d_err),
    .wb_adr_o(adr), .wb_cyc_o(cyc), .wb_stb_o(stb),
    .wb_we_o(we), .wb_sel_o(sel),
    .wb_dat_i(wb_dat), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  kronos_imem_wb #(.TIMEOUT(0)) dut2 (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_req(instr_req),
    .instr_data(d2_data), .instr_ack(d2_ack), .instr_err(d2_err),
    .wb_adr_o(adr2), .wb_cyc_o(cyc2), .wb_stb_o(stb2),
    .wb_we_o(we2), .wb_sel_o(sel2),
    .wb_dat_i(32'h1234_5678), .wb_ack_i(1'b0), .wb_err_i(1'b0)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a[31:2] == 30'h80) return 32'h0000_0013;
    return a ^ 32'hCAFE_0000;
  endfunction

  assign s_hit  = cyc && stb && (s_cnt == s_wait) && (s_mode != 3);
  assign wb_ack = f_ack | (s_hit && (s_mode != 1));
  assign wb_err = f_err | (s_hit && (s_mode == 1 || s_mode == 2));
  assign wb_dat = mem(adr);

  always @(posedge clk) begin
    if (!cyc || wb_ack || wb_err) s_cnt <= 0;
    else s_cnt <= s_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: expected outputs for the current cycle, advanced
  // from the inputs seen at each clock edge.
  initial begin
    bit          m_ok;
    logic        m_cyc, m_ack, m_err, n_busy;
    logic [31:0] m_adr, m_data, n_adr;
    int          m_wait;
    m_ok = 0;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("cyc", cyc, m_cyc);
        chk("stb", stb, m_cyc);
        chk("adr", adr, m_adr);
        chk("ack", d_ack, m_ack);
        chk("err", d_err, m_err);
        chk("data", d_data, m_data);
        chk("we", we, 1'b0);
        chk("sel", sel, 4'hF);
        chk("t0_cyc", cyc2, n_busy);
        chk("t0_adr", adr2, n_adr);
        chk("t0_ack", d2_ack, 1'b0);
        chk("t0_data", d2_data, 32'h0);
      end
      if (rst) begin
        m_ok = 1;
        m_cyc = 0; m_adr = 0; m_ack = 0; m_err = 0; m_data = 0;
        m_wait = 0;
        n_busy = 0; n_adr = 0;
      end else begin
        if (m_cyc) begin
          m_ack = 0;
          if (wb_err || wb_ack || m_wait == T1 - 1) begin
            m_cyc = 0;
            if (instr_req && instr_addr[31:2] == m_adr[31:2]) begin
              m_ack = 1;
              m_err = wb_err || !wb_ack;
              m_data = m_err ? 32'h0 : wb_dat;
            end
          end else begin
            m_wait++;
          end
        end else begin
          m_ack = 0;
          if (instr_req) begin
            m_cyc = 1;
            m_adr = instr_addr & ~32'h3;
            m_wait = 0;
          end
        end
        if (!n_busy && instr_req) begin
          n_busy = 1;
          n_adr = instr_addr & ~32'h3;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int lim, output int n, output bit got);
    n = 0;
    got = 0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (d_ack) begin
        got = 1;
        break;
      end
      if (cyc) n++;
    end
  endtask

  initial begin
    int n;
    bit got;
    bit seen;

    step(); step();
    chk("rst_cyc", cyc, 1'b0);
    chk("rst_adr", adr, 32'h0);
    chk("rst_ack", d_ack, 1'b0);
    chk("rst_data", d_data, 32'h0);
    chk("rst_err", d_err, 1'b0);

    // zero-wait back-to-back
    rst = 0; instr_req = 1; instr_addr = 32'h100;
    step();
    chk("zw_cyc1", cyc, 1'b1);
    chk("zw_adr1", adr, 32'h100);
    step();
    chk("zw_ack1", d_ack, 1'b1);
    chk("zw_dat1", d_data, 32'hCAFE_0100);
    chk("zw_cyc2", cyc, 1'b0);
    instr_addr = 32'h104;
    step();
    chk("zw_adr3", adr, 32'h104);
    step();
    chk("zw_ack4", d_ack, 1'b1);
    chk("zw_dat4", d_data, 32'hCAFE_0104);
    instr_req = 0;
    step();
    chk("zw_idle", cyc, 1'b0);

    // three wait states
    s_wait = 3; instr_req = 1; instr_addr = 32'h200;
    wait_ack(20, n, got);
    chk("ws_got", got, 1'b1);
    chk("ws_cycles", n, 4);
    chk("ws_dat", d_data, 32'h0000_0013);
    chk("ws_err", d_err, 1'b0);
    instr_req = 0;
    step();

    // redirect while waiting
    s_wait = 2; instr_req = 1; instr_addr = 32'h303;
    step();
    chk("rd_adr0", adr, 32'h300);
    instr_addr = 32'h800;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (d_ack) seen = 1;
      if (!cyc) break;
    end
    chk("rd_noack", seen, 1'b0);
    chk("rd_drop", cyc, 1'b0);
    step();
    chk("rd_cyc", cyc, 1'b1);
    chk("rd_adr", adr, 32'h800);
    wait_ack(10, n, got);
    chk("rd_got", got, 1'b1);
    chk("rd_dat", d_data, 32'hCAFE_0800);
    instr_req = 0;
    step();

    // bus error, then ack+err together via lookahead
    s_mode = 1; s_wait = 1; instr_req = 1; instr_addr = 32'h400;
    wait_ack(10, n, got);
    chk("be_got", got, 1'b1);
    chk("be_err", d_err, 1'b1);
    chk("be_dat", d_data, 32'h0);
    s_mode = 2; instr_addr = 32'h404;
    wait_ack(10, n, got);
    chk("ae_got", got, 1'b1);
    chk("ae_err", d_err, 1'b1);
    chk("ae_dat", d_data, 32'h0);
    instr_req = 0; s_mode = 0;
    step();

    // timeout on silent slave, late ack ignored
    s_mode = 3; instr_req = 1; instr_addr = 32'h500;
    wait_ack(20, n, got);
    chk("to_got", got, 1'b1);
    chk("to_cycles", n, T1);
    chk("to_err", d_err, 1'b1);
    chk("to_dat", d_data, 32'h0);
    chk("to_cyc", cyc, 1'b0);
    instr_req = 0; f_ack = 1;
    step();
    chk("late_ack1", d_ack, 1'b0);
    step();
    chk("late_ack2", d_ack, 1'b0);
    chk("late_cyc", cyc, 1'b0);
    f_ack = 0;

    // TIMEOUT=0 instance still waiting on its first access
    repeat (20) step();
    chk("t0_hold_cyc", cyc2, 1'b1);
    chk("t0_hold_adr", adr2, 32'h100);
    chk("t0_hold_ack", d2_ack, 1'b0);

    // reset mid-BUSY
    instr_req = 1; instr_addr = 32'h600;
    step();
    chk("rb_cyc", cyc, 1'b1);
    rst = 1;
    step();
    chk("rb_cyc0", cyc, 1'b0);
    chk("rb_ack0", d_ack, 1'b0);
    chk("rb_adr0", adr, 32'h0);
    rst = 0; s_mode = 0; s_wait = 0; instr_addr = 32'h0;
    step();
    chk("pr_cyc", cyc, 1'b1);
    chk("pr_adr", adr, 32'h0);
    step();
    chk("pr_ack", d_ack, 1'b1);
    chk("pr_dat", d_data, 32'hCAFE_0000);
    chk("pr_err", d_err, 1'b0);
    instr_req = 0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
